// File: rtl/start_reg_stack_if.sv
// Strobe/data bundle between control, operator panel and the start register stack.
// With START_REG_PREV_EN defined, also carries the previous start value.
interface start_reg_stack_if #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
);
    logic              do_arr_reg_start;
    logic [ADDR_W-1:0] arr_reg_start_data;
    logic              do_reg_start_inc;
    logic              do_mod_reg_start;
    logic [ADDR_W-1:0] mod_reg_start_data;
    logic              do_call;
    logic [ADDR_W-1:0] call_target;
    logic              do_ret;
    logic              clear_err;
    logic [ADDR_W-1:0] reg_start_value;
    logic [CNT_W-1:0]  stack_depth;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_overflow;
    logic              stack_underflow;
`ifdef START_REG_PREV_EN
    logic [ADDR_W-1:0] prev_start_value;
`endif

    modport master (
        output do_arr_reg_start, arr_reg_start_data, do_reg_start_inc,
               do_mod_reg_start, mod_reg_start_data, do_call, call_target,
               do_ret, clear_err,
        input  reg_start_value, stack_depth, stack_full, stack_empty,
               stack_overflow, stack_underflow
`ifdef START_REG_PREV_EN
        , input prev_start_value
`endif
    );

    modport slave (
        input  do_arr_reg_start, arr_reg_start_data, do_reg_start_inc,
               do_mod_reg_start, mod_reg_start_data, do_call, call_target,
               do_ret, clear_err,
        output reg_start_value, stack_depth, stack_full, stack_empty,
               stack_overflow, stack_underflow
`ifdef START_REG_PREV_EN
        , output prev_start_value
`endif
    );
endinterface

// File: rtl/start_reg_stack.sv
// Start/instruction address register with a return-address LIFO for call/ret.
// Optional macro START_REG_PREV_EN adds prev_start_value (old value on every jump).
module start_reg_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    start_reg_stack_if.slave   bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    logic [ADDR_W-1:0] reg_start_r;
    logic [CNT_W-1:0]  depth_r;
    logic              overflow_r;
    logic              underflow_r;
    logic [ADDR_W-1:0] stack_r [DEPTH];

    logic [ADDR_W-1:0] reg_start_nx_s;
    logic [CNT_W-1:0]  depth_nx_s;
    logic              push_s;
    logic              jump_s;
    logic              ovf_set_s;
    logic              unf_set_s;
    logic              full_s;
    logic              empty_s;
    logic [IDX_W-1:0]  push_idx_s;
    logic [IDX_W-1:0]  top_idx_s;

    assign full_s     = (depth_r == CNT_W'(DEPTH));
    assign empty_s    = (depth_r == CNT_W'(0));
    assign push_idx_s = IDX_W'(depth_r);
    assign top_idx_s  = IDX_W'(depth_r - CNT_W'(1));

    // Single prioritised action per cycle: arr > call > ret > inc > mod.
    always_comb begin
        reg_start_nx_s = reg_start_r;
        depth_nx_s     = depth_r;
        push_s         = 1'b0;
        jump_s         = 1'b0;
        ovf_set_s      = 1'b0;
        unf_set_s      = 1'b0;
        if (bus.do_arr_reg_start) begin
            reg_start_nx_s = bus.arr_reg_start_data;
            jump_s         = 1'b1;
        end else if (bus.do_call) begin
            if (full_s) begin
                ovf_set_s = 1'b1;
            end else begin
                push_s         = 1'b1;
                jump_s         = 1'b1;
                reg_start_nx_s = bus.call_target;
                depth_nx_s     = depth_r + CNT_W'(1);
            end
        end else if (bus.do_ret) begin
            if (empty_s) begin
                unf_set_s = 1'b1;
            end else begin
                jump_s         = 1'b1;
                reg_start_nx_s = stack_r[top_idx_s];
                depth_nx_s     = depth_r - CNT_W'(1);
            end
        end else if (bus.do_reg_start_inc) begin
            reg_start_nx_s = addr_inc(reg_start_r);
        end else if (bus.do_mod_reg_start) begin
            reg_start_nx_s = bus.mod_reg_start_data;
            jump_s         = 1'b1;
        end else begin
            reg_start_nx_s = reg_start_r;
        end
    end

    // Start register, depth counter and sticky error flags (set beats clear).
    always_ff @(posedge clk) begin
        if (!resetn) begin
            reg_start_r <= ADDR_W'(0);
            depth_r     <= CNT_W'(0);
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            reg_start_r <= reg_start_nx_s;
            depth_r     <= depth_nx_s;
            overflow_r  <= ovf_set_s | (overflow_r & ~bus.clear_err);
            underflow_r <= unf_set_s | (underflow_r & ~bus.clear_err);
        end
    end

    // Stack entries are unobservable until pushed, so they carry no reset.
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            stack_r[push_idx_s] <= addr_inc(reg_start_r);
        end
    end

    assign bus.reg_start_value = reg_start_r;
    assign bus.stack_depth     = depth_r;
    assign bus.stack_full      = full_s;
    assign bus.stack_empty     = empty_s;
    assign bus.stack_overflow  = overflow_r;
    assign bus.stack_underflow = underflow_r;

`ifdef START_REG_PREV_EN
    logic [ADDR_W-1:0] prev_r;

    // Remember where we jumped from; plain increments and rejected call/ret do not count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_r <= ADDR_W'(0);
        end else if (jump_s) begin
            prev_r <= reg_start_r;
        end else begin
            prev_r <= prev_r;
        end
    end

    assign bus.prev_start_value = prev_r;
`endif
endmodule

// File: tb/tb_start_reg_stack.sv
// Directed self-checking bench for start_reg_stack (DEPTH=4, ADDR_W=12).
module tb_start_reg_stack;
    logic clk;
    logic resetn;
    int   errors;
    int   checks;

    start_reg_stack_if #(.ADDR_W(12), .DEPTH(4)) bus ();

    start_reg_stack #(.ADDR_W(12), .DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        bus.do_arr_reg_start   = 1'b0;
        bus.arr_reg_start_data = 12'o0000;
        bus.do_reg_start_inc   = 1'b0;
        bus.do_mod_reg_start   = 1'b0;
        bus.mod_reg_start_data = 12'o0000;
        bus.do_call            = 1'b0;
        bus.call_target        = 12'o0000;
        bus.do_ret             = 1'b0;
        bus.clear_err          = 1'b0;
    endtask

    // One clock: inputs set before this call are applied, then outputs sampled #1 later.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        resetn = 1'b1;
        checks++; if (bus.reg_start_value !== 12'o0000) begin errors++; $display("FAIL rst_reg got %o exp 0000", bus.reg_start_value); end
        checks++; if (bus.stack_depth !== 3'd0) begin errors++; $display("FAIL rst_depth got %0d exp 0", bus.stack_depth); end
        checks++; if (bus.stack_empty !== 1'b1 || bus.stack_full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %b%b exp 10", bus.stack_empty, bus.stack_full); end
        checks++; if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b exp 00", bus.stack_overflow, bus.stack_underflow); end
        for (int i = 0; i < 3; i++) begin
            bus.do_reg_start_inc = 1'b1;
            tick();
        end
        checks++; if (bus.reg_start_value !== 12'o0003) begin errors++; $display("FAIL inc3 got %o exp 0003", bus.reg_start_value); end
        checks++; if (bus.stack_empty !== 1'b1 || bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL inc3_status got %b%b%b exp 100", bus.stack_empty, bus.stack_overflow, bus.stack_underflow); end
    endtask

    task automatic test_wrap_call_ret();
        bus.do_arr_reg_start = 1'b1; bus.arr_reg_start_data = 12'o7777; tick();
        checks++; if (bus.reg_start_value !== 12'o7777) begin errors++; $display("FAIL arr_load got %o exp 7777", bus.reg_start_value); end
        bus.do_reg_start_inc = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0000) begin errors++; $display("FAIL inc_wrap got %o exp 0000", bus.reg_start_value); end
        bus.do_call = 1'b1; bus.call_target = 12'o0100; tick();
        checks++; if (bus.reg_start_value !== 12'o0100 || bus.stack_depth !== 3'd1) begin errors++; $display("FAIL call1 got %o/%0d exp 0100/1", bus.reg_start_value, bus.stack_depth); end
        bus.do_ret = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0001 || bus.stack_depth !== 3'd0) begin errors++; $display("FAIL ret1 got %o/%0d exp 0001/0", bus.reg_start_value, bus.stack_depth); end
    endtask

    task automatic test_overflow_underflow();
        logic [11:0] tgt [4];
        logic [11:0] ret_exp [4];
        tgt[0] = 12'o0100; tgt[1] = 12'o0200; tgt[2] = 12'o0300; tgt[3] = 12'o0400;
        ret_exp[0] = 12'o0302; ret_exp[1] = 12'o0202; ret_exp[2] = 12'o0102; ret_exp[3] = 12'o0011;
        bus.do_arr_reg_start = 1'b1; bus.arr_reg_start_data = 12'o0010; tick();
        for (int i = 0; i < 4; i++) begin
            bus.do_call = 1'b1; bus.call_target = tgt[i]; tick();
            bus.do_reg_start_inc = 1'b1; tick();
        end
        checks++; if (bus.stack_depth !== 3'd4 || bus.stack_full !== 1'b1) begin errors++; $display("FAIL full got %0d/%b exp 4/1", bus.stack_depth, bus.stack_full); end
        checks++; if (bus.reg_start_value !== 12'o0401) begin errors++; $display("FAIL full_reg got %o exp 0401", bus.reg_start_value); end
        bus.do_call = 1'b1; bus.call_target = 12'o0500; tick();
        checks++; if (bus.reg_start_value !== 12'o0401 || bus.stack_depth !== 3'd4 || bus.stack_overflow !== 1'b1) begin errors++; $display("FAIL overflow got %o/%0d/%b exp 0401/4/1", bus.reg_start_value, bus.stack_depth, bus.stack_overflow); end
        for (int i = 0; i < 4; i++) begin
            bus.do_ret = 1'b1; tick();
            checks++; if (bus.reg_start_value !== ret_exp[i] || bus.stack_depth !== 3'(3 - i)) begin errors++; $display("FAIL ret_order%0d got %o/%0d exp %o/%0d", i, bus.reg_start_value, bus.stack_depth, ret_exp[i], 3 - i); end
        end
        checks++; if (bus.stack_empty !== 1'b1 || bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL empty_after_rets got %b/%b exp 1/0", bus.stack_empty, bus.stack_underflow); end
        bus.do_ret = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0011 || bus.stack_underflow !== 1'b1 || bus.stack_depth !== 3'd0) begin errors++; $display("FAIL underflow got %o/%b/%0d exp 0011/1/0", bus.reg_start_value, bus.stack_underflow, bus.stack_depth); end
    endtask

    task automatic test_clear_err();
        bus.clear_err = 1'b1; tick();
        checks++; if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL clear got %b%b exp 00", bus.stack_overflow, bus.stack_underflow); end
        for (int i = 0; i < 4; i++) begin
            bus.do_call = 1'b1; bus.call_target = 12'o0000; tick();
        end
        bus.do_call = 1'b1; bus.call_target = 12'o0777; bus.clear_err = 1'b1; tick();
        checks++; if (bus.stack_overflow !== 1'b1 || bus.stack_depth !== 3'd4 || bus.reg_start_value !== 12'o0000) begin errors++; $display("FAIL set_beats_clear got %b/%0d/%o exp 1/4/0000", bus.stack_overflow, bus.stack_depth, bus.reg_start_value); end
        bus.clear_err = 1'b1; tick();
        checks++; if (bus.stack_overflow !== 1'b0) begin errors++; $display("FAIL clear2 got %b exp 0", bus.stack_overflow); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.do_arr_reg_start = 1'b1; bus.arr_reg_start_data = 12'o0500;
        bus.do_call = 1'b1; bus.call_target = 12'o0200; bus.do_reg_start_inc = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0500 || bus.stack_depth !== 3'd0) begin errors++; $display("FAIL arr_wins got %o/%0d exp 0500/0", bus.reg_start_value, bus.stack_depth); end
        bus.do_arr_reg_start = 1'b1; bus.arr_reg_start_data = 12'o0500; bus.do_ret = 1'b1; tick();
        checks++; if (bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL arr_masks_ret got %b exp 0", bus.stack_underflow); end
        bus.do_call = 1'b1; bus.call_target = 12'o0100; tick();
        bus.do_call = 1'b1; bus.call_target = 12'o0300; bus.do_ret = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0300 || bus.stack_depth !== 3'd2) begin errors++; $display("FAIL call_beats_ret got %o/%0d exp 0300/2", bus.reg_start_value, bus.stack_depth); end
        bus.do_ret = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0101 || bus.stack_depth !== 3'd1) begin errors++; $display("FAIL ret_after_pair got %o/%0d exp 0101/1", bus.reg_start_value, bus.stack_depth); end
        bus.do_mod_reg_start = 1'b1; bus.mod_reg_start_data = 12'o0017; tick();
        checks++; if (bus.reg_start_value !== 12'o0017) begin errors++; $display("FAIL mod got %o exp 0017", bus.reg_start_value); end
        bus.do_mod_reg_start = 1'b1; bus.mod_reg_start_data = 12'o0777; bus.do_reg_start_inc = 1'b1; tick();
        checks++; if (bus.reg_start_value !== 12'o0020) begin errors++; $display("FAIL inc_beats_mod got %o exp 0020", bus.reg_start_value); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.do_ret = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            bus.do_call = 1'b1; bus.call_target = 12'o0600; tick();
        end
        checks++; if (bus.stack_depth !== 3'd3 || bus.stack_underflow !== 1'b1) begin errors++; $display("FAIL pre_reset got %0d/%b exp 3/1", bus.stack_depth, bus.stack_underflow); end
        bus.do_reg_start_inc = 1'b1;
        resetn = 1'b0; tick(); resetn = 1'b1;
        checks++; if (bus.reg_start_value !== 12'o0000 || bus.stack_depth !== 3'd0) begin errors++; $display("FAIL mid_reset got %o/%0d exp 0000/0", bus.reg_start_value, bus.stack_depth); end
        checks++; if (bus.stack_overflow !== 1'b0 || bus.stack_underflow !== 1'b0) begin errors++; $display("FAIL mid_reset_flags got %b%b exp 00", bus.stack_overflow, bus.stack_underflow); end
`ifdef START_REG_PREV_EN
        checks++; if (bus.prev_start_value !== 12'o0000) begin errors++; $display("FAIL prev_rst got %o exp 0000", bus.prev_start_value); end
        bus.do_arr_reg_start = 1'b1; bus.arr_reg_start_data = 12'o0042; tick();
        bus.do_mod_reg_start = 1'b1; bus.mod_reg_start_data = 12'o0017; tick();
        checks++; if (bus.prev_start_value !== 12'o0042) begin errors++; $display("FAIL prev_mod got %o exp 0042", bus.prev_start_value); end
        bus.do_reg_start_inc = 1'b1; tick();
        bus.do_ret = 1'b1; tick();
        checks++; if (bus.prev_start_value !== 12'o0042) begin errors++; $display("FAIL prev_hold got %o exp 0042", bus.prev_start_value); end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        resetn = 1'b0;
        idle();
        test_reset();
        test_wrap_call_ret();
        test_overflow_underflow();
        test_clear_err();
        test_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
